// File: rtl/synth_tdm_clk_gen.sv
// rtl/synth_tdm_clk_gen.sv - single-clock I2S/TDM bit/word clock, frame tick and osc/env slot tick generator
// All outputs are registered from the next-cycle counter values, so they line up with the counters' cycle.
module synth_tdm_clk_gen #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNEL_NUM = 2,
  parameter int BCK_HALF    = 64,
  parameter int VOICES      = 8,
  parameter int V_OSC       = 4,
  parameter int V_ENVS      = 2 * V_OSC,
  localparam int N_OSC  = VOICES * V_OSC,
  localparam int N_ENV  = VOICES * V_ENVS,
  localparam int SLOT_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1,
  localparam int BIT_W  = $clog2(DATA_WIDTH),
  localparam int OIDX_W = (N_OSC > 1) ? $clog2(N_OSC) : 1,
  localparam int EIDX_W = (N_ENV > 1) ? $clog2(N_ENV) : 1
) (
  input  logic              OSC_CLK,
  input  logic              iRST_N,
  input  logic              iENABLE,
  input  logic              iMODE,
  output logic              oAUD_BCK,
  output logic              oLRCK,
  output logic              oBCK_FALL,
  output logic              oSAMPLE_TICK,
  output logic [SLOT_W-1:0] oSLOT,
  output logic [BIT_W-1:0]  oBIT,
  output logic              oOSC_TICK,
  output logic [OIDX_W-1:0] oOSC_IDX,
  output logic              oENV_TICK,
  output logic [EIDX_W-1:0] oENV_IDX
);

  localparam int FRAME = 2 * BCK_HALF * DATA_WIDTH * CHANNEL_NUM;
  localparam int N_MAX = (N_OSC > N_ENV) ? N_OSC : N_ENV;
  localparam int ACC_W = $clog2(FRAME + N_MAX) + 1;
  localparam int SUB_W = $clog2(2 * BCK_HALF);

  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(2 * BCK_HALF - 1);
  localparam logic [SUB_W-1:0]  SUB_MID   = SUB_W'(BCK_HALF);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNEL_NUM - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(CHANNEL_NUM / 2);
  localparam logic [ACC_W-1:0]  FRAME_A   = ACC_W'(FRAME);
  localparam logic [ACC_W-1:0]  OSC_STEP  = ACC_W'(N_OSC);
  localparam logic [ACC_W-1:0]  ENV_STEP  = ACC_W'(N_ENV);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_n;
  logic [SUB_W-1:0]  sub, sub_n;
  logic [BIT_W-1:0]  bitc, bit_n;
  logic [SLOT_W-1:0] slot, slot_n, lr_slot;
  logic              mode, mode_n;
  logic              last, run_n, start_n, lrck_n;
  logic [ACC_W-1:0]  osc_acc, osc_acc_n, osc_sum;
  logic [ACC_W-1:0]  env_acc, env_acc_n, env_sum;
  logic              osc_hit, env_hit;
  logic [OIDX_W-1:0] osc_cnt, osc_cnt_n, osc_base;
  logic [EIDX_W-1:0] env_cnt, env_cnt_n, env_base;

  always_comb begin
    last    = (state == RUN) && (sub == SUB_LAST) && (bitc == BIT_LAST) && (slot == SLOT_LAST);
    state_n = state;
    run_n   = 1'b1;
    start_n = 1'b0;
    // iENABLE only matters while stopped or on the last cycle of a frame
    if (state != RUN || last) begin
      run_n   = iENABLE;
      start_n = iENABLE;
      if (iENABLE)
        state_n = RUN;
      else if (state == RUN)
        state_n = DRAIN;
    end

    sub_n  = '0;
    bit_n  = '0;
    slot_n = '0;
    if (run_n && !start_n) begin
      sub_n  = sub + SUB_W'(1);
      bit_n  = bitc;
      slot_n = slot;
      if (sub == SUB_LAST) begin
        sub_n = '0;
        bit_n = bitc + BIT_W'(1);
        if (bitc == BIT_LAST) begin
          bit_n  = '0;
          slot_n = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
        end
      end
    end

    mode_n  = start_n ? iMODE : mode;
    // I2S word clock leads the slot by one bit: look at the slot of the following bit
    lr_slot = slot_n;
    if (bit_n == BIT_LAST)
      lr_slot = (slot_n == SLOT_LAST) ? '0 : slot_n + SLOT_W'(1);
    lrck_n  = run_n && (mode_n ? ((bit_n == BIT_LAST) && (slot_n == SLOT_LAST))
                               : (lr_slot >= SLOT_HALF));

    osc_sum   = (start_n ? ACC_W'(0) : osc_acc) + OSC_STEP;
    osc_hit   = run_n && (osc_sum >= FRAME_A);
    osc_acc_n = !run_n ? '0 : (osc_hit ? osc_sum - FRAME_A : osc_sum);
    osc_base  = start_n ? '0 : osc_cnt;
    osc_cnt_n = !run_n ? '0 : osc_base + OIDX_W'(osc_hit);

    env_sum   = (start_n ? ACC_W'(0) : env_acc) + ENV_STEP;
    env_hit   = run_n && (env_sum >= FRAME_A);
    env_acc_n = !run_n ? '0 : (env_hit ? env_sum - FRAME_A : env_sum);
    env_base  = start_n ? '0 : env_cnt;
    env_cnt_n = !run_n ? '0 : env_base + EIDX_W'(env_hit);
  end

  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= IDLE;
      sub          <= '0;
      bitc         <= '0;
      slot         <= '0;
      mode         <= 1'b0;
      osc_acc      <= '0;
      env_acc      <= '0;
      osc_cnt      <= '0;
      env_cnt      <= '0;
      oAUD_BCK     <= 1'b0;
      oLRCK        <= 1'b0;
      oBCK_FALL    <= 1'b0;
      oSAMPLE_TICK <= 1'b0;
      oSLOT        <= '0;
      oBIT         <= '0;
      oOSC_TICK    <= 1'b0;
      oOSC_IDX     <= '0;
      oENV_TICK    <= 1'b0;
      oENV_IDX     <= '0;
    end else begin
      state        <= state_n;
      sub          <= sub_n;
      bitc         <= bit_n;
      slot         <= slot_n;
      mode         <= mode_n;
      osc_acc      <= osc_acc_n;
      env_acc      <= env_acc_n;
      osc_cnt      <= osc_cnt_n;
      env_cnt      <= env_cnt_n;
      oAUD_BCK     <= run_n && (sub_n >= SUB_MID);
      oLRCK        <= lrck_n;
      oBCK_FALL    <= run_n && (sub_n == '0);
      oSAMPLE_TICK <= start_n;
      oSLOT        <= slot_n;
      oBIT         <= bit_n;
      oOSC_TICK    <= osc_hit;
      oOSC_IDX     <= run_n ? osc_base : '0;
      oENV_TICK    <= env_hit;
      oENV_IDX     <= run_n ? env_base : '0;
    end
  end

endmodule
